// File: rtl/tcam_loader_pkg.sv
// Shared definitions for the TCAM rule loader: FSM encoding and rule-table slicing.
package tcam_loader_pkg;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_CLEAR = 2'd1;
  localparam logic [1:0] ST_LOAD  = 2'd2;
  localparam logic [1:0] ST_DONE  = 2'd3;

  localparam int MAX_VEC_W = 4096;

  // Rule i of a packed parameter vector; caller truncates the result to w bits.
  function automatic logic [MAX_VEC_W-1:0] rule_slice(input logic [MAX_VEC_W-1:0] vec,
                                                      input int idx, input int w);
    return vec >> (idx * w);
  endfunction

endpackage

// File: rtl/tcam_set_skid.sv
// One-entry registered valid/ready stage driving the TCAM set port.
module tcam_set_skid #(
  parameter int AW = 4,
  parameter int KW = 48,
  parameter int DW = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          i_load,
  input  logic [AW-1:0] i_addr,
  input  logic [KW-1:0] i_key,
  input  logic [KW-1:0] i_xmask,
  input  logic [DW-1:0] i_data,
  input  logic          i_clr,
  input  logic          i_ready,
  output logic          o_valid,
  output logic [AW-1:0] o_addr,
  output logic [KW-1:0] o_key,
  output logic [KW-1:0] o_xmask,
  output logic [DW-1:0] o_data,
  output logic          o_clr
);

  always_ff @(posedge clk) begin
    if (rst) begin
      o_valid <= 1'b0;
      o_addr  <= '0;
      o_key   <= '0;
      o_xmask <= '0;
      o_data  <= '0;
      o_clr   <= 1'b0;
    end else if (i_load) begin
      o_valid <= 1'b1;
      o_addr  <= i_addr;
      o_key   <= i_key;
      o_xmask <= i_xmask;
      o_data  <= i_data;
      o_clr   <= i_clr;
    end else if (i_ready) begin
      o_valid <= 1'b0;
    end
  end

endmodule

// File: rtl/tcam_rule_loader.sv
// TCAM programming engine: optional clear sweep, init rule load, then runtime update forwarding.
module tcam_rule_loader import tcam_loader_pkg::*; #(
  parameter int TCAM_ADDR_WIDTH = 4,
  parameter int TCAM_KEY_WIDTH  = 48,
  parameter int TCAM_DATA_WIDTH = 4,
  parameter int N_RULES         = 3,
  parameter logic [N_RULES*TCAM_KEY_WIDTH-1:0] RULE_KEYS =
    {48'h555555555501, 48'h555555555502, 48'h555555555503},
  parameter logic [N_RULES*TCAM_KEY_WIDTH-1:0]  RULE_XMASKS = '0,
  parameter logic [N_RULES*TCAM_DATA_WIDTH-1:0] RULE_DATA   = {4'd2, 4'd1, 4'd0},
  parameter int RULE_BASE_ADDR  = 1,
  parameter int CLEAR_ON_START  = 1,
  parameter int AUTO_START      = 1
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       start,
  output logic                       busy,
  output logic                       done,
  output logic [TCAM_ADDR_WIDTH-1:0] set_addr,
  output logic [TCAM_KEY_WIDTH-1:0]  set_key,
  output logic [TCAM_KEY_WIDTH-1:0]  set_xmask,
  output logic [TCAM_DATA_WIDTH-1:0] set_data,
  output logic                       set_clr,
  output logic                       set_valid,
  input  logic                       set_ready,
  input  logic [TCAM_ADDR_WIDTH-1:0] upd_addr,
  input  logic [TCAM_KEY_WIDTH-1:0]  upd_key,
  input  logic [TCAM_KEY_WIDTH-1:0]  upd_xmask,
  input  logic [TCAM_DATA_WIDTH-1:0] upd_data,
  input  logic                       upd_clr,
  input  logic                       upd_valid,
  output logic                       upd_ready
);

  localparam int AW    = TCAM_ADDR_WIDTH;
  localparam int KW    = TCAM_KEY_WIDTH;
  localparam int DW    = TCAM_DATA_WIDTH;
  localparam int DEPTH = 2 ** AW;
  localparam logic [1:0]    ST_START      = (CLEAR_ON_START != 0) ? ST_CLEAR : ST_LOAD;
  localparam logic [1:0]    ST_RST        = (AUTO_START != 0) ? ST_START : ST_IDLE;
  localparam logic [AW-1:0] IDX_LAST_CLR  = AW'(DEPTH - 1);
  localparam logic [AW-1:0] IDX_LAST_RULE = AW'(N_RULES - 1);
  localparam logic [AW-1:0] BASE          = AW'(RULE_BASE_ADDR);

  if (N_RULES < 1 || RULE_BASE_ADDR + N_RULES > DEPTH ||
      N_RULES * KW > MAX_VEC_W || N_RULES * DW > MAX_VEC_W) begin : g_bad_cfg
    $error("tcam_rule_loader: rule table does not fit the TCAM");
  end

  // Rule ROM padded to the full depth so the sweep counter indexes it directly.
  logic [KW-1:0] w_rom_key   [DEPTH];
  logic [KW-1:0] w_rom_xmask [DEPTH];
  logic [DW-1:0] w_rom_data  [DEPTH];

  for (genvar g = 0; g < DEPTH; g++) begin : g_rom
    if (g < N_RULES) begin : g_rule
      assign w_rom_key[g]   = KW'(rule_slice(MAX_VEC_W'(RULE_KEYS), g, KW));
      assign w_rom_xmask[g] = KW'(rule_slice(MAX_VEC_W'(RULE_XMASKS), g, KW));
      assign w_rom_data[g]  = DW'(rule_slice(MAX_VEC_W'(RULE_DATA), g, DW));
    end else begin : g_pad
      assign w_rom_key[g]   = '0;
      assign w_rom_xmask[g] = '0;
      assign w_rom_data[g]  = '0;
    end
  end

  logic [1:0]    r_state, w_state_nxt, w_adv_state, w_pos_state;
  logic [AW-1:0] r_idx, w_idx_nxt, w_adv_idx, w_pos_idx;
  logic          r_busy, r_done, r_pend;
  logic          w_xfer, w_sweep, w_accept, w_sweep_load, w_upd_fire, w_load;
  logic          w_sw_clr;
  logic [AW-1:0] w_sw_addr;

  assign w_xfer   = set_valid && set_ready;
  assign w_sweep  = (r_state == ST_CLEAR) || (r_state == ST_LOAD);
  assign w_accept = ((r_state == ST_IDLE) || (r_state == ST_DONE)) && (start || r_pend) && !set_valid;

  // Sweep position following the entry currently held in the skid register.
  always_comb begin
    w_adv_state = r_state;
    w_adv_idx   = r_idx + 1'b1;
    case (r_state)
      ST_CLEAR: if (r_idx == IDX_LAST_CLR) begin
        w_adv_state = ST_LOAD;
        w_adv_idx   = '0;
      end
      ST_LOAD: if (r_idx == IDX_LAST_RULE) begin
        w_adv_state = ST_DONE;
        w_adv_idx   = '0;
      end
      default: ;
    endcase
  end

  always_comb begin
    w_state_nxt = r_state;
    w_idx_nxt   = r_idx;
    if (w_accept) begin
      w_state_nxt = ST_START;
      w_idx_nxt   = '0;
    end else if (w_sweep && w_xfer) begin
      w_state_nxt = w_adv_state;
      w_idx_nxt   = w_adv_idx;
    end
  end

  // The entry to load next: the first one on (re)entry, otherwise the one after the skid's.
  assign w_pos_state  = w_accept ? ST_START : (set_valid ? w_adv_state : r_state);
  assign w_pos_idx    = w_accept ? '0 : (set_valid ? w_adv_idx : r_idx);
  assign w_sweep_load = w_accept || (w_sweep && (!set_valid || (set_ready && w_adv_state != ST_DONE)));
  assign w_sw_clr     = (w_pos_state == ST_CLEAR);
  assign w_sw_addr    = w_sw_clr ? w_pos_idx : BASE + w_pos_idx;

  assign upd_ready  = !rst && (r_state == ST_DONE) && !start && !r_pend && (!set_valid || set_ready);
  assign w_upd_fire = upd_valid && upd_ready;
  assign w_load     = w_sweep_load || w_upd_fire;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_RST;
      r_idx   <= '0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_pend  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_idx   <= w_idx_nxt;
      r_busy  <= (w_state_nxt == ST_CLEAR) || (w_state_nxt == ST_LOAD);
      r_done  <= (w_state_nxt == ST_DONE);
      r_pend  <= !w_accept && (r_pend || ((r_state == ST_DONE) && start));
    end
  end

  assign busy = r_busy;
  assign done = r_done;

  tcam_set_skid #(.AW(AW), .KW(KW), .DW(DW)) u_skid (
    .clk     (clk),
    .rst     (rst),
    .i_load  (w_load),
    .i_addr  (w_upd_fire ? upd_addr  : w_sw_addr),
    .i_key   (w_upd_fire ? upd_key   : (w_sw_clr ? '0 : w_rom_key[w_pos_idx])),
    .i_xmask (w_upd_fire ? upd_xmask : (w_sw_clr ? '0 : w_rom_xmask[w_pos_idx])),
    .i_data  (w_upd_fire ? upd_data  : (w_sw_clr ? '0 : w_rom_data[w_pos_idx])),
    .i_clr   (w_upd_fire ? upd_clr   : w_sw_clr),
    .i_ready (set_ready),
    .o_valid (set_valid),
    .o_addr  (set_addr),
    .o_key   (set_key),
    .o_xmask (set_xmask),
    .o_data  (set_data),
    .o_clr   (set_clr)
  );

endmodule
